// File: rtl/fetch_instruction_pkg.sv
// fetch_instruction_pkg: shared widths, reset address and opcode values of the faux CPU.
package fetch_instruction_pkg;

    localparam int INSTRUCTION_WIDTH = 25;
    localparam int WIDTH_OPCODE      = 5;
    localparam int PC_WIDTH          = 12;

    localparam logic [PC_WIDTH-1:0] RESET_PC = '0;

    localparam logic [WIDTH_OPCODE-1:0] INSTR_NOP  = 5'h00;
    localparam logic [WIDTH_OPCODE-1:0] INSTR_ADD  = 5'h01;
    localparam logic [WIDTH_OPCODE-1:0] INSTR_LR   = 5'h02;
    localparam logic [WIDTH_OPCODE-1:0] INSTR_SR   = 5'h03;
    localparam logic [WIDTH_OPCODE-1:0] INSTR_HALT = 5'h1F;

endpackage

// File: rtl/fetch_instruction_if.sv
// fetch_instruction_if: instruction-memory port, decode handshake and redirect input of the fetch stage.
interface fetch_instruction_if #(
    parameter int INSTRUCTION_WIDTH = fetch_instruction_pkg::INSTRUCTION_WIDTH,
    parameter int PC_WIDTH          = fetch_instruction_pkg::PC_WIDTH
);
    logic                         imem_en;
    logic [PC_WIDTH-1:0]          imem_addr;
    logic [INSTRUCTION_WIDTH-1:0] imem_rdata;
    logic                         fetch_valid;
    logic                         fetch_ready;
    logic [INSTRUCTION_WIDTH-1:0] fetch_instruction;
    logic [PC_WIDTH-1:0]          fetch_pc;
    logic                         redirect_valid;
    logic [PC_WIDTH-1:0]          redirect_pc;
    logic                         halted;

    // Fetch stage side.
    modport master (
        output imem_en, imem_addr, fetch_valid, fetch_instruction, fetch_pc, halted,
        input  imem_rdata, fetch_ready, redirect_valid, redirect_pc
    );

    // Memory / decode / execute side.
    modport slave (
        input  imem_en, imem_addr, fetch_valid, fetch_instruction, fetch_pc, halted,
        output imem_rdata, fetch_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: 2-entry FIFO of {instruction, pc} with push, pop, flush and occupancy count.
module fetch_skid_buffer
    import fetch_instruction_pkg::*;
#(
    parameter int DATA_WIDTH = INSTRUCTION_WIDTH + PC_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic [1:0]            count_o
);
    logic [DATA_WIDTH-1:0] entry_q [2];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [1:0]            count_q;

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                entry_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign head_data_o = entry_q[rd_ptr_q];
    assign count_o     = count_q;
endmodule

// File: rtl/fetch_instruction.sv
// fetch_instruction: program counter, memory-read issue, halt tracking and skid queue feeding decode.
module fetch_instruction #(
    parameter int                      INSTRUCTION_WIDTH = fetch_instruction_pkg::INSTRUCTION_WIDTH,
    parameter int                      WIDTH_OPCODE      = fetch_instruction_pkg::WIDTH_OPCODE,
    parameter int                      PC_WIDTH          = fetch_instruction_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]     RESET_PC          = fetch_instruction_pkg::RESET_PC,
    parameter logic [WIDTH_OPCODE-1:0] INSTR_HALT        = fetch_instruction_pkg::INSTR_HALT
) (
    input logic                 clk,
    input logic                 reset,
    fetch_instruction_if.master bus
);
    localparam int ENTRY_W = INSTRUCTION_WIDTH + PC_WIDTH;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic                inflight_q, inflight_d;
    logic                halted_q, halted_d;

    logic [1:0]          count;
    logic [ENTRY_W-1:0]  head;
    logic [2:0]          occupancy;
    logic                valid;
    logic                pop;
    logic                push;
    logic                issue;
    logic                req;
    logic [PC_WIDTH-1:0] req_addr;
    logic                halt_push;

    // Handshake and read-request decision; the occupancy term counts the read still in flight
    // so the queue can never be over-committed.
    always_comb begin
        valid     = !reset && (count != 2'd0) && !bus.redirect_valid;
        pop       = valid && bus.fetch_ready;
        occupancy = {1'b0, count} - {2'b00, pop} + {2'b00, inflight_q};
        issue     = !halted_q && (occupancy < 3'd2);
        req       = !reset && (bus.redirect_valid || issue);
        if (reset) begin
            req_addr = RESET_PC;
        end else if (bus.redirect_valid) begin
            req_addr = bus.redirect_pc;
        end else begin
            req_addr = pc_q;
        end
        // A response arriving after halt was pushed, or in a redirect cycle, is dropped.
        push      = !reset && inflight_q && !halted_q && !bus.redirect_valid;
        halt_push = push && (bus.imem_rdata[INSTRUCTION_WIDTH-1 -: WIDTH_OPCODE] == INSTR_HALT);
    end

    // Next-state for PC, halt flag and in-flight read tracking; redirect wins over everything.
    always_comb begin
        pc_d          = pc_q;
        halted_d      = halted_q;
        inflight_d    = req;
        inflight_pc_d = req_addr;
        if (bus.redirect_valid) begin
            pc_d     = bus.redirect_pc + PC_WIDTH'(1);
            halted_d = 1'b0;
        end else begin
            if (issue) begin
                pc_d = pc_q + PC_WIDTH'(1);
            end
            if (halt_push) begin
                halted_d = 1'b1;
            end
        end
    end

    // State registers; reset also forgets any read in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            halted_q      <= 1'b0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            halted_q      <= halted_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_skid_buffer #(
        .DATA_WIDTH (ENTRY_W)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (bus.redirect_valid),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i ({bus.imem_rdata, inflight_pc_q}),
        .head_data_o (head),
        .count_o     (count)
    );

    assign bus.imem_en           = req;
    assign bus.imem_addr         = req_addr;
    assign bus.fetch_valid       = valid;
    assign bus.fetch_instruction = head[ENTRY_W-1:PC_WIDTH];
    assign bus.fetch_pc          = head[PC_WIDTH-1:0];
    assign bus.halted            = halted_q;
endmodule

// File: tb/tb_fetch_instruction.sv
// tb_fetch_instruction: directed scenarios plus randomized traffic against a program-order reference model.
module tb_fetch_instruction;
    localparam int         IW      = 25;
    localparam int         PW      = 12;
    localparam logic [4:0] HALT_OP = 5'h1F;

    logic clk = 1'b0;
    logic reset;

    fetch_instruction_if #(.INSTRUCTION_WIDTH(IW), .PC_WIDTH(PW)) bus ();

    fetch_instruction #(
        .INSTRUCTION_WIDTH (IW),
        .WIDTH_OPCODE      (5),
        .PC_WIDTH          (PW),
        .RESET_PC          (12'h000),
        .INSTR_HALT        (HALT_OP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data one cycle after the request.
    logic [IW-1:0] mem [4096];
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Reference model: decode must see program order from the last reset/redirect target,
    // nothing after a delivered halt, and a stable head while stalled.
    logic [PW-1:0] exp_pc;
    bit            halt_seen;
    int            stall;
    bit            hold_prev;
    logic [PW-1:0] prev_pc;
    logic [IW-1:0] prev_instr;
    int            accepts = 0;

    always @(negedge clk) begin
        if (reset) begin
            check_val("rst_valid", 32'(bus.fetch_valid), 32'd0);
            check_val("rst_imem_en", 32'(bus.imem_en), 32'd0);
            exp_pc    = 12'h000;
            halt_seen = 0;
            stall     = 0;
            hold_prev = 0;
        end else begin
            if (hold_prev && !bus.redirect_valid) begin
                check_val("hold_valid", 32'(bus.fetch_valid), 32'd1);
                check_val("hold_pc", 32'(bus.fetch_pc), 32'(prev_pc));
                check_val("hold_instr", 32'(bus.fetch_instruction), 32'(prev_instr));
            end
            if (bus.redirect_valid) begin
                check_val("redir_valid", 32'(bus.fetch_valid), 32'd0);
                check_val("redir_imem_en", 32'(bus.imem_en), 32'd1);
                check_val("redir_addr", 32'(bus.imem_addr), 32'(bus.redirect_pc));
                exp_pc    = bus.redirect_pc;
                halt_seen = 0;
                stall     = 0;
                hold_prev = 0;
            end else begin
                if (halt_seen) begin
                    check_val("post_halt_valid", 32'(bus.fetch_valid), 32'd0);
                    check_val("post_halt_imem_en", 32'(bus.imem_en), 32'd0);
                    check_val("post_halt_halted", 32'(bus.halted), 32'd1);
                end
                if (bus.fetch_valid && bus.fetch_ready) begin
                    check_val("deliver_pc", 32'(bus.fetch_pc), 32'(exp_pc));
                    check_val("deliver_instr", 32'(bus.fetch_instruction), 32'(mem[exp_pc]));
                    if (mem[exp_pc][IW-1 -: 5] == HALT_OP) halt_seen = 1;
                    exp_pc = exp_pc + 12'd1;
                    accepts++;
                    stall = 0;
                end else if (bus.fetch_ready && !halt_seen) begin
                    stall++;
                    check_val("stall_bound", 32'(stall <= 3), 32'd1);
                end
                hold_prev  = bus.fetch_valid && !bus.fetch_ready;
                prev_pc    = bus.fetch_pc;
                prev_instr = bus.fetch_instruction;
            end
        end
    end

    logic [IW-1:0] w;

    initial begin
        reset              = 1'b1;
        bus.fetch_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        for (int a = 0; a < 4096; a++) begin
            w = IW'($urandom);
            if (w[IW-1 -: 5] == HALT_OP) w[IW-1] = 1'b0;
            mem[a] = w;
        end
        mem[0] = 25'h0440010;
        mem[1] = 25'h0480020;
        mem[2] = 25'h0288000;
        mem[3] = 25'h0610030;
        mem[4] = 25'h1F00000;   // opcode 5'h1F

        // Reset values and sequential fetch up to the halt word.
        repeat (3) to_next();
        mid();
        check_val("rst_instr", 32'(bus.fetch_instruction), 32'd0);
        check_val("rst_pc", 32'(bus.fetch_pc), 32'd0);
        check_val("rst_halted", 32'(bus.halted), 32'd0);
        check_val("rst_addr", 32'(bus.imem_addr), 32'd0);
        to_next();
        reset = 1'b0;
        mid();
        check_val("c0_imem_en", 32'(bus.imem_en), 32'd1);
        check_val("c0_addr", 32'(bus.imem_addr), 32'd0);
        check_val("c0_valid", 32'(bus.fetch_valid), 32'd0);
        to_next();
        mid();
        check_val("c1_valid", 32'(bus.fetch_valid), 32'd0);
        to_next();
        for (int k = 0; k < 5; k++) begin
            mid();
            check_val("seq_valid", 32'(bus.fetch_valid), 32'd1);
            check_val("seq_pc", 32'(bus.fetch_pc), 32'(k));
            check_val("seq_instr", 32'(bus.fetch_instruction), 32'(mem[k]));
            to_next();
        end
        repeat (3) begin
            mid();
            check_val("halt_halted", 32'(bus.halted), 32'd1);
            check_val("halt_imem_en", 32'(bus.imem_en), 32'd0);
            to_next();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 12'h000;
        mid();
        check_val("resume_valid_r", 32'(bus.fetch_valid), 32'd0);
        to_next();
        bus.redirect_valid = 1'b0;
        mid();
        check_val("resume_halted", 32'(bus.halted), 32'd0);
        to_next();
        mid();
        check_val("resume_valid", 32'(bus.fetch_valid), 32'd1);
        check_val("resume_pc", 32'(bus.fetch_pc), 32'd0);
        to_next();

        // Backpressure: decode stalls cycles 3..8.
        reset = 1'b1;
        repeat (2) to_next();
        reset = 1'b0;
        for (int c = 0; c < 14; c++) begin
            bus.fetch_ready = !(c >= 3 && c <= 8);
            mid();
            if (c >= 4 && c <= 8) check_val("bp_imem_en", 32'(bus.imem_en), 32'd0);
            if (c >= 3 && c <= 8) check_val("bp_head_pc", 32'(bus.fetch_pc), 32'd1);
            if (c >= 9 && c <= 12) check_val("bp_pc", 32'(bus.fetch_pc), 32'(c - 8));
            to_next();
        end

        // Redirect with one entry queued and a read in flight, then with two entries queued (wrap).
        reset = 1'b1;
        repeat (2) to_next();
        reset           = 1'b0;
        bus.fetch_ready = 1'b0;
        repeat (2) to_next();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 12'h020;
        mid();
        check_val("r1_valid_r", 32'(bus.fetch_valid), 32'd0);
        to_next();
        bus.redirect_valid = 1'b0;
        mid();
        check_val("r1_valid_r1", 32'(bus.fetch_valid), 32'd0);
        to_next();
        mid();
        check_val("r1_valid_r2", 32'(bus.fetch_valid), 32'd1);
        check_val("r1_pc_r2", 32'(bus.fetch_pc), 32'h020);
        to_next();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 12'hFFF;
        mid();
        check_val("r2_valid_r", 32'(bus.fetch_valid), 32'd0);
        to_next();
        bus.redirect_valid = 1'b0;
        bus.fetch_ready    = 1'b1;
        to_next();
        mid();
        check_val("wrap_pc0", 32'(bus.fetch_pc), 32'hFFF);
        to_next();
        mid();
        check_val("wrap_pc1", 32'(bus.fetch_pc), 32'h000);
        to_next();
        to_next();

        // Reset with two entries buffered.
        bus.fetch_ready = 1'b0;
        repeat (3) to_next();
        reset = 1'b1;
        mid();
        check_val("mid_rst_valid", 32'(bus.fetch_valid), 32'd0);
        to_next();
        reset           = 1'b0;
        bus.fetch_ready = 1'b1;
        mid();
        check_val("post_rst_c0_valid", 32'(bus.fetch_valid), 32'd0);
        to_next();
        to_next();
        mid();
        check_val("post_rst_c2_pc", 32'(bus.fetch_pc), 32'd0);
        check_val("post_rst_c2_valid", 32'(bus.fetch_valid), 32'd1);
        to_next();

        // Randomized traffic with scattered halt words, redirects and resets.
        reset = 1'b1;
        for (int a = 8; a < 4096; a++) begin
            if ($urandom_range(0, 31) == 0) mem[a] = {HALT_OP, 20'($urandom)};
        end
        repeat (2) to_next();
        reset = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            bus.fetch_ready    = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 39) == 0);
            bus.redirect_pc    = 12'($urandom_range(0, 4095));
            reset              = ($urandom_range(0, 299) == 0);
            to_next();
        end
        reset              = 1'b0;
        bus.redirect_valid = 1'b0;
        to_next();
        check_val("deliveries", 32'(accepts > 300), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
